// File: rtl/mac_drain_pkg.sv
// Shared types and requantization for the MAC result drain.
// Optional build macro: MAC_DRAIN_RELU_EN (clamp negative features to zero).
package mac_drain_pkg;

  localparam int IN_W  = 13;
  localparam int OUT_W = 7;
  localparam int SHIFT = 3;
  localparam int NUM_N = 4;

  localparam int SAT_MAX = (2 ** (OUT_W - 1)) - 1;
  localparam int SAT_MIN = -(2 ** (OUT_W - 1));

  typedef enum logic {IDLE, SEND} state_t;

  // n[0] is neuron4 ... n[3] is neuron7
  typedef struct packed {
    logic [NUM_N-1:0][IN_W-1:0] n;
  } mac_vec_t;

  // Floor shift, optional ReLU, then saturate into the output range.
  function automatic logic [OUT_W-1:0] requant(input logic signed [IN_W-1:0] x);
    logic signed [IN_W-1:0] t;
    logic [OUT_W-1:0]       r;
    t = x >>> SHIFT;
`ifdef MAC_DRAIN_RELU_EN
    if (t < 0) t = '0;
`endif
    if (int'(t) > SAT_MAX)      r = OUT_W'(SAT_MAX);
    else if (int'(t) < SAT_MIN) r = OUT_W'(SAT_MIN);
    else                        r = t[OUT_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/mac_result_drain_if.sv
// Output feature stream: one requantized neuron per valid/ready beat.
interface mac_result_drain_if #(parameter int OUT_W = mac_drain_pkg::OUT_W);
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [1:0]       out_idx;
  logic             out_last;

  modport master (output out_valid, out_data, out_idx, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_idx, out_last, output out_ready);
endinterface

// File: rtl/mac_vec_fifo.sv
// Synchronous FIFO of MAC result vectors. A push into a full FIFO is
// accepted when a pop happens at the same edge.
module mac_vec_fifo
  import mac_drain_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  mac_vec_t                   wr_data,
  output mac_vec_t                   rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  mac_vec_t       mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           wr_en, rd_en;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign rd_en   = pop && !empty;
  assign wr_en   = push && (!full || rd_en);

  // Next pointer and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mac_result_drain.sv
// Drains 4-neuron MAC result vectors: capture on the MAC ready pulse into a
// FIFO, then stream one requantized neuron per beat.
// Optional build macro: MAC_DRAIN_RELU_EN (ReLU before saturation).
module mac_result_drain
  import mac_drain_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_ready_mac1,
  input  logic signed [IN_W-1:0] neuron4,
  input  logic signed [IN_W-1:0] neuron5,
  input  logic signed [IN_W-1:0] neuron6,
  input  logic signed [IN_W-1:0] neuron7,
  mac_result_drain_if.master     strm,
  output logic                   overflow_err,
  output logic                   busy
);

  mac_vec_t                  in_vec, fifo_rd;
  logic                      fifo_pop, fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  state_t           state_q, state_d;
  mac_vec_t         hold_q, hold_d;
  logic [1:0]       idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic             ovf_q, ovf_d;

  assign in_vec.n = {neuron7, neuron6, neuron5, neuron4};

  mac_vec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (in_ready_mac1),
    .pop     (fifo_pop),
    .wr_data (in_vec),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Next-state for the drain FSM; output beat is computed from the
  // next holding value so the first beat appears the cycle after the pop.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          hold_d   = fifo_rd;
          idx_d    = 2'd0;
          valid_d  = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (valid_q && strm.out_ready) begin
          if (idx_q != 2'd3) begin
            idx_d = idx_q + 1'b1;
          end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            hold_d   = fifo_rd;
            idx_d    = 2'd0;
          end else begin
            idx_d   = 2'd0;
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (valid_d) begin
      data_d = requant($signed(hold_d.n[idx_d]));
      last_d = (idx_d == 2'd3);
    end else begin
      data_d = '0;
      last_d = 1'b0;
    end

    // A vector is lost only when the FIFO is full and nothing leaves it.
    ovf_d = ovf_q | (in_ready_mac1 && fifo_full && !fifo_pop);
  end

  // FSM state and registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  assign strm.out_valid = valid_q;
  assign strm.out_data  = data_q;
  assign strm.out_idx   = idx_q;
  assign strm.out_last  = last_q;
  assign overflow_err   = ovf_q;
  assign busy           = (fifo_count != '0) || (state_q == SEND);

endmodule

// File: tb/tb_mac_result_drain.sv
// Self-checking bench for mac_result_drain: directed steps plus random
// traffic against a beat-queue reference model.
module tb_mac_result_drain;
  import mac_drain_pkg::*;

  localparam int FD  = 4;
  localparam int DIV = 1 << SHIFT;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_ready_mac1;
  logic signed [IN_W-1:0] n4, n5, n6, n7;
  logic                   overflow_err, busy;

  mac_result_drain_if strm();

  mac_result_drain #(.FIFO_DEPTH(FD)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_ready_mac1 (in_ready_mac1),
    .neuron4       (n4),
    .neuron5       (n5),
    .neuron6       (n6),
    .neuron7       (n7),
    .strm          (strm),
    .overflow_err  (overflow_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d;
    int idx;
    bit last;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    beats = 0;
  bit    ovf_exp = 0;

  // Reference requantization: floor divide, optional ReLU, clamp.
  function automatic int ref_q(int x);
    int t;
    t = (x - (((x % DIV) + DIV) % DIV)) / DIV;
`ifdef MAC_DRAIN_RELU_EN
    if (t < 0) t = 0;
`endif
    if (t > 63)  t = 63;
    if (t < -64) t = -64;
    return t;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic rand_n();
    n4 = IN_W'($urandom);
    n5 = IN_W'($urandom);
    n6 = IN_W'($urandom);
    n7 = IN_W'($urandom);
  endtask

  // One clock: model the edge, then check sticky/busy and stall stability.
  task automatic step(input bit pulse);
    beat_t           b;
    bit              hs, stall;
    int              cnt;
    logic [OUT_W-1:0] pd;
    logic [1:0]      pi;
    logic            pl;
    in_ready_mac1 = pulse;
    hs    = (strm.out_valid === 1'b1) && (strm.out_ready === 1'b1);
    stall = (strm.out_valid === 1'b1) && (strm.out_ready === 1'b0);
    pd = strm.out_data; pi = strm.out_idx; pl = strm.out_last;
    if (rst !== 1'b1) begin
      if (hs) begin
        beats++;
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else begin
          b = exp_q.pop_front();
          check("data", $signed(strm.out_data), b.d);
          check("idx",  strm.out_idx, b.idx);
          check("last", strm.out_last, b.last);
        end
      end
      if (pulse) begin
        cnt = (exp_q.size() + 3) / 4;
        if (cnt < FD + 1) begin
          exp_q.push_back('{ref_q(int'(n4)), 0, 1'b0});
          exp_q.push_back('{ref_q(int'(n5)), 1, 1'b0});
          exp_q.push_back('{ref_q(int'(n6)), 2, 1'b0});
          exp_q.push_back('{ref_q(int'(n7)), 3, 1'b1});
        end else ovf_exp = 1'b1;
      end
    end
    @(posedge clk); #1;
    in_ready_mac1 = 1'b0;
    if (rst === 1'b1) begin
      exp_q.delete();
      ovf_exp = 1'b0;
    end
    check("overflow_err", overflow_err, ovf_exp);
    check("busy", busy, exp_q.size() > 0);
    if (stall && rst !== 1'b1) begin
      check("stall_valid", strm.out_valid, 1);
      check("stall_data", strm.out_data, pd);
      check("stall_idx", strm.out_idx, pi);
      check("stall_last", strm.out_last, pl);
    end
  endtask

  task automatic drain();
    int k = 0;
    strm.out_ready = 1'b1;
    while ((exp_q.size() > 0 || strm.out_valid === 1'b1) && k < 200) begin
      step(1'b0);
      k++;
    end
    check("drain_in_time", k < 200, 1);
    check("drain_idle", (exp_q.size() == 0) && (strm.out_valid === 1'b0), 1);
  endtask

  task automatic wait_idx(input logic [1:0] target);
    int k = 0;
    while (!(strm.out_valid === 1'b1 && strm.out_idx === target) && k < 50) begin
      step(1'b0);
      k++;
    end
    check("wait_idx_in_time", k < 50, 1);
  endtask

  int b0;

  initial begin
    rst = 1'b1; in_ready_mac1 = 1'b0; strm.out_ready = 1'b0;
    n4 = '0; n5 = '0; n6 = '0; n7 = '0;
    step(1'b0); step(1'b0);
    rst = 1'b0;
    check("rst_valid", strm.out_valid, 0);
    check("rst_data", strm.out_data, 0);
    check("rst_idx", strm.out_idx, 0);
    check("rst_last", strm.out_last, 0);
    check("rst_ovf", overflow_err, 0);
    check("rst_busy", busy, 0);

    // Basic vector and two-cycle latency
    n4 = 13'sd100; n5 = -13'sd50; n6 = 13'sd1000; n7 = 13'sd7;
    strm.out_ready = 1'b1;
    step(1'b1);
    check("lat_e0_valid", strm.out_valid, 0);
    step(1'b0);
    check("lat_e1_valid", strm.out_valid, 1);
    check("first_data", $signed(strm.out_data), 12);
    check("first_idx", strm.out_idx, 0);
    check("first_last", strm.out_last, 0);
    drain();

    // Negative saturation
    rand_n(); n4 = -13'sd4096;
    step(1'b1);
    drain();

    // Backpressure at idx 1
    rand_n(); strm.out_ready = 1'b1;
    step(1'b1);
    wait_idx(2'd1);
    strm.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0);
    drain();

    // Back-to-back pulses: 8 contiguous beats
    strm.out_ready = 1'b1;
    rand_n(); step(1'b1);
    rand_n(); step(1'b1);
    for (int i = 0; i < 8; i++) begin
      check("b2b_valid", strm.out_valid, 1);
      step(1'b0);
    end
    check("b2b_idle", strm.out_valid, 0);
    drain();

    // Overflow: six pulses with the stream stalled
    strm.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rand_n(); step(1'b1);
    end
    check("ovf_set", overflow_err, 1);
    b0 = beats;
    drain();
    check("ovf_beats", beats - b0, 20);

    // Reset in the middle of a transfer
    strm.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_n(); step(1'b1);
    end
    wait_idx(2'd2);
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    check("midrst_valid", strm.out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ovf", overflow_err, 0);
    b0 = beats;
    rand_n(); step(1'b1);
    drain();
    check("midrst_beats", beats - b0, 4);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      strm.out_ready = ($urandom_range(0, 3) != 0);
      rand_n();
      if ($urandom_range(0, 7) == 0) n5 = ($urandom_range(0, 1) != 0) ? 13'sh0FFF : 13'sh1000;
      step($urandom_range(0, 3) == 0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
